boot_uart_receiver: RTL and testbench
=====================================

# boot_uart_receiver

Serial-to-byte front end of the boot loader path. Recovers 8N1 (optionally 8E1) asynchronous serial characters from the `rx` pin and emits each good character as a one-cycle `out_valid` / `out_char` pulse. These outputs feed the hex parser's `in_valid` / `in_char` inputs directly. Framing and parity faults are flagged and the character is dropped.

## Interface
- `clk_frequency`, default 50_000_000: clock frequency in Hz.
- `baud_rate`, default 115_200: serial bit rate.
- `char_width`, default 8: data bits per character.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line; idles high; asynchronous to `clk`.
- `out_valid`  out  1  one-cycle pulse: `out_char` holds a good character.
- `out_char`  out  `char_width`  received character, LSB received first.
- `frame_error`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_error`  out  1  one-cycle pulse: parity mismatch. Constant 0 without the parity macro.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- D = round(`clk_frequency` / `baud_rate`), i.e. cycles per bit. Elaboration fails with `$error` if D < 4. Default D = 434.
- `rx` passes through a 2-flop synchronizer whose flops reset to 1. All decisions use the synchronized value `rxs`.
- Down-counter `bit_cnt` of width `$clog2(D)`. A tick occurs when `bit_cnt` == 0; on a tick it reloads D−1.
- Index counter `idx` counts data bits, 0 to `char_width`−1.
- IDLE: when `rxs` == 0, go to START and load `bit_cnt` = D/2−1.
- START: on tick, sample at mid-bit.
  - `rxs` == 0: go to DATA with `idx` = 0.
  - `rxs` == 1: glitch; return to IDLE silently.
- DATA: on each tick, shift `rxs` into the MSB of the shift register (LSB-first line order).
  - After bit `char_width`−1, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: on tick, store the sampled bit, then go to STOP.
- STOP: on tick, sample `rxs`.
  - `rxs` == 1 and parity good: pulse `out_valid`, load `out_char`, go to IDLE.
  - `rxs` == 1 and parity bad: pulse `parity_error`, leave `out_char` unchanged, go to IDLE.
  - `rxs` == 0: pulse `frame_error`, no `out_valid`, go to BREAK.
- BREAK: wait for `rxs` == 1, then go to IDLE. A held-low line never generates repeated characters.
- Error pulses and `out_valid` are mutually exclusive in any cycle.

## Timing
- Reset values:
  - `out_valid`, `frame_error`, `parity_error`, `busy` = 0.
  - `out_char` = 0.
  - State = IDLE; synchronizer flops = 1.
- All outputs are registered.
- `out_char` is stable from the `out_valid` pulse until the next `out_valid`.
- Latency: `out_valid` asserts 2 + D/2 + 9·D cycles after the first `clk` edge that sees `rx` low. Parity adds D. The bench tolerance is ±1 cycle.
- `busy` rises 2 cycles after `rx` falls. It falls in the cycle the result pulse is issued, or when BREAK exits.
- Back-to-back characters (stop bit followed immediately by the next start bit) are accepted. The IDLE→START transition occurs within D/2 cycles of the stop-bit sample.
- There is no backpressure. The consumer must accept every `out_valid` pulse; the hex parser always does.
- `reset_n` asserted mid-character aborts the character immediately: no pulse, and all outputs return to their reset values.

## Configuration
- `BOOT_UART_RX_PARITY_EN` defined:
  - One even-parity bit follows the data bits; the PARITY state exists.
  - A parity mismatch pulses `parity_error` and suppresses `out_valid`.
- Not defined:
  - 8N1 only; the PARITY state is not compiled.
  - `parity_error` is tied to 0.

## Test plan
All scenarios use `clk_frequency` = 1600 and `baud_rate` = 100, giving D = 16.
- Send 0x41 ('A') as 8N1 → one `out_valid` with `out_char` = 0x41 at 2+8+144 cycles ±1; `frame_error` = 0.
- Send "1F\r\n" back-to-back → four `out_valid` pulses carrying 0x31, 0x46, 0x0D, 0x0A, in order, none lost.
- 3-cycle low glitch on idle `rx` → no `out_valid`; `busy` high for about 8 cycles, then back to IDLE.
- Send 0x55 with the stop bit driven low, then hold `rx` low for 100 cycles → exactly one `frame_error` pulse, no `out_valid`. `busy` stays high until `rx` returns high.
- Assert `reset_n` low after the fourth data bit of 0xA5 → outputs read 0 and state is IDLE. A following 0x3C is received correctly.
- With parity enabled, send 0x07 with parity bit 0 (wrong) → `parity_error` pulse, no `out_valid`. Sending 0x07 with parity bit 1 → `out_valid`, `out_char` = 0x07.

Source files
------------

// File: rtl/boot_uart_receiver_if.sv
// ---------------------------------------------------------------------------
// boot_uart_receiver_if
// Groups the serial input and the character/status outputs of the boot UART
// receiver so they can be passed to the hex parser side as one bundle.
//
// Parameter:
//   char_width   data bits per character
// Signals:
//   rx           serial line (idles high, asynchronous to clk)
//   out_valid    one-cycle pulse, out_char holds a good character
//   out_char     received character, LSB received first
//   frame_error  one-cycle pulse, stop bit sampled low
//   parity_error one-cycle pulse, parity mismatch (0 when parity is disabled)
//   busy         receiver is not idle
// Modports:
//   master       the receiver (consumes rx, drives everything else)
//   slave        the line driver / character consumer
// ---------------------------------------------------------------------------
interface boot_uart_receiver_if #(
    parameter int char_width = 8
);
    logic                  rx;
    logic                  out_valid;
    logic [char_width-1:0] out_char;
    logic                  frame_error;
    logic                  parity_error;
    logic                  busy;

    modport master (
        input  rx,
        output out_valid,
        output out_char,
        output frame_error,
        output parity_error,
        output busy
    );

    modport slave (
        output rx,
        input  out_valid,
        input  out_char,
        input  frame_error,
        input  parity_error,
        input  busy
    );
endinterface

// File: rtl/boot_uart_receiver.sv
// ---------------------------------------------------------------------------
// boot_uart_receiver
// Recovers asynchronous serial characters (8N1, or 8E1 when the macro
// BOOT_UART_RX_PARITY_EN is defined) from bus.rx and emits each good
// character as a one-cycle out_valid/out_char pulse. Framing and parity
// faults raise a one-cycle error pulse and the character is dropped.
//
// Parameters:
//   clk_frequency  clock frequency in Hz
//   baud_rate      serial bit rate
//   char_width     data bits per character (>= 2)
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   bus            boot_uart_receiver_if.master (rx in; out_valid, out_char,
//                  frame_error, parity_error, busy out -- all registered)
// Optional feature macro:
//   BOOT_UART_RX_PARITY_EN  adds one even-parity bit after the data bits
// ---------------------------------------------------------------------------
module boot_uart_receiver #(
    parameter int clk_frequency = 50_000_000,
    parameter int baud_rate     = 115_200,
    parameter int char_width    = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    boot_uart_receiver_if.master        bus
);
    // Cycles per bit, rounded to nearest.
    localparam int D  = (clk_frequency + baud_rate / 2) / baud_rate;
    localparam int CW = $clog2(D);
    localparam int IW = (char_width > 1) ? $clog2(char_width) : 1;

    localparam logic [CW-1:0] bit_reload = CW'(D - 1);
    localparam logic [CW-1:0] half_bit   = CW'(D / 2 - 1);
    localparam logic [IW-1:0] last_idx   = IW'(char_width - 1);

    generate
        if (D < 4) begin : g_bad_divisor
            $error("boot_uart_receiver: clk_frequency/baud_rate gives fewer than 4 cycles per bit");
        end
        if (char_width < 2) begin : g_bad_width
            $error("boot_uart_receiver: char_width must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef BOOT_UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t                state_reg;
    logic                  rx_meta_reg;
    logic                  rxs;
    logic [CW-1:0]         bit_cnt_reg;
    logic [IW-1:0]         idx_reg;
    logic [char_width-1:0] shift_reg;
    logic [char_width-1:0] out_char_reg;
    logic                  out_valid_reg;
    logic                  frame_error_reg;
    logic                  busy_reg;
    logic                  tick;

    // Two-flop synchronizer; flops reset to the idle line level so reset
    // release never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rxs         <= 1'b1;
        end else begin
            rx_meta_reg <= bus.rx;
            rxs         <= rx_meta_reg;
        end
    end

    assign tick = (bit_cnt_reg == '0);

`ifdef BOOT_UART_RX_PARITY_EN
    logic parity_bit_reg;
    logic parity_error_reg;
    assign bus.parity_error = parity_error_reg;
`else
    assign bus.parity_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= '0;
            idx_reg          <= '0;
            shift_reg        <= '0;
            out_char_reg     <= '0;
            out_valid_reg    <= 1'b0;
            frame_error_reg  <= 1'b0;
            busy_reg         <= 1'b0;
`ifdef BOOT_UART_RX_PARITY_EN
            parity_bit_reg   <= 1'b0;
            parity_error_reg <= 1'b0;
`endif
        end else begin
            out_valid_reg   <= 1'b0;
            frame_error_reg <= 1'b0;
`ifdef BOOT_UART_RX_PARITY_EN
            parity_error_reg <= 1'b0;
`endif
            // Free-running bit timer while a character is in progress; the
            // IDLE branch below overrides it with the half-bit load.
            if (state_reg != IDLE) begin
                bit_cnt_reg <= tick ? bit_reload : bit_cnt_reg - 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (!rxs) begin
                        state_reg   <= START;
                        bit_cnt_reg <= half_bit;
                        busy_reg    <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rxs) begin
                            state_reg <= DATA;
                            idx_reg   <= '0;
                        end else begin
                            // Line went back high by mid-bit: treat as noise.
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        // LSB arrives first, so shift in from the top.
                        shift_reg <= {rxs, shift_reg[char_width-1:1]};
                        if (idx_reg == last_idx) begin
`ifdef BOOT_UART_RX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
`ifdef BOOT_UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        parity_bit_reg <= rxs;
                        state_reg      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (rxs) begin
`ifdef BOOT_UART_RX_PARITY_EN
                            // Even parity: data plus parity bit has an even
                            // number of ones.
                            if (^{shift_reg, parity_bit_reg}) begin
                                parity_error_reg <= 1'b1;
                            end else begin
                                out_valid_reg <= 1'b1;
                                out_char_reg  <= shift_reg;
                            end
`else
                            out_valid_reg <= 1'b1;
                            out_char_reg  <= shift_reg;
`endif
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            frame_error_reg <= 1'b1;
                            state_reg       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Hold here until the line is released so a stuck-low
                    // line cannot produce a stream of bogus characters.
                    if (rxs) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.out_char    = out_char_reg;
    assign bus.frame_error = frame_error_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_boot_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_boot_uart_receiver
// Self-checking bench for boot_uart_receiver at clk_frequency=1600,
// baud_rate=100 (16 cycles per bit). Directed table vectors, hand-written
// corner sequences (glitch, break, reset mid-character, back-to-back) and
// random characters judged by a rule-level reference model.
// ---------------------------------------------------------------------------
module tb_boot_uart_receiver;
    localparam int D   = 16;
`ifdef BOOT_UART_RX_PARITY_EN
    localparam int LAT = 2 + D / 2 + 9 * D + D;
`else
    localparam int LAT = 2 + D / 2 + 9 * D;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic rx;

    always #5 clk = ~clk;

    boot_uart_receiver_if #(.char_width(8)) bus ();
    assign bus.rx = rx;

    boot_uart_receiver #(
        .clk_frequency(1600),
        .baud_rate    (100),
        .char_width   (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Monitor state
    int         cycle            = 0;
    int         valid_cnt        = 0;
    int         frame_cnt        = 0;
    int         parity_cnt       = 0;
    int         busy_cycles      = 0;
    int         excl_bad         = 0;
    int         last_valid_cycle = 0;
    logic [7:0] last_char        = 8'h00;
    logic [7:0] got_q[$];

    // Reference state: what out_char must currently hold.
    logic [7:0] exp_last_char = 8'h00;

    always @(posedge clk) begin
        cycle++;
        #1;
        if (bus.out_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cycle = cycle;
            last_char        = bus.out_char;
            got_q.push_back(bus.out_char);
        end
        if (bus.frame_error === 1'b1)  frame_cnt++;
        if (bus.parity_error === 1'b1) parity_cnt++;
        if ((int'(bus.out_valid) + int'(bus.frame_error) + int'(bus.parity_error)) > 1) excl_bad++;
        if (bus.busy === 1'b1) busy_cycles++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Called at a falling clock edge; holds rx for one bit period.
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (D) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_v, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef BOOT_UART_RX_PARITY_EN
        drive_bit(par_bit);
`else
        if (par_bit === 1'bx) $display("note: parity bit unused");
`endif
        drive_bit(stop_v);
    endtask

    // Rule-level model: {valid, frame_error, parity_error}
    function automatic logic [2:0] model_outcome(input logic [7:0] d, input logic s, input logic p);
        if (!s) return 3'b010;
`ifdef BOOT_UART_RX_PARITY_EN
        if ((^d) != p) return 3'b001;
`else
        if (p === 1'bz) return 3'b000;
`endif
        return 3'b100;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] data, input logic stop_v,
                             input logic par_bit, input logic [2:0] exp);
        int v0, f0, p0, start;
        v0 = valid_cnt; f0 = frame_cnt; p0 = parity_cnt;
        start = cycle + 1;
        send_frame(data, stop_v, par_bit);
        rx = 1'b1;
        repeat (2 * D) @(negedge clk);
        $display("%s data=0x%02h stop=%0b par=%0b -> valid=+%0d frame=+%0d parity=+%0d out_char=0x%02h",
                 tag, data, stop_v, par_bit, valid_cnt - v0, frame_cnt - f0, parity_cnt - p0, bus.out_char);
        check({tag, "_valid"},  valid_cnt - v0,  int'(exp[2]));
        check({tag, "_frame"},  frame_cnt - f0,  int'(exp[1]));
        check({tag, "_parity"}, parity_cnt - p0, int'(exp[0]));
        if (exp[2]) begin
            exp_last_char = data;
            check({tag, "_char"}, int'(last_char), int'(data));
            check_range({tag, "_latency"}, last_valid_cycle - start, LAT - 1, LAT + 1);
        end
        check({tag, "_held"}, int'(bus.out_char), int'(exp_last_char));
        check({tag, "_idle"}, int'(bus.busy), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par_ok;
        logic [2:0] exp;   // {valid, frame_error, parity_error}
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [7:0] msg [4];
        int         v0, f0, b0;
        logic [7:0] d;
        logic       s, pbad, pb;

        vecs.push_back('{8'h41, 1'b1, 1'b1, 3'b100});
        vecs.push_back('{8'h00, 1'b1, 1'b1, 3'b100});
        vecs.push_back('{8'hFF, 1'b1, 1'b1, 3'b100});
        vecs.push_back('{8'h80, 1'b1, 1'b1, 3'b100});
        vecs.push_back('{8'h3C, 1'b0, 1'b1, 3'b010});
        vecs.push_back('{8'hA5, 1'b1, 1'b1, 3'b100});
`ifdef BOOT_UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, 3'b001});
        vecs.push_back('{8'h07, 1'b1, 1'b1, 3'b100});
`endif

        // Reset values
        rx = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid",    int'(bus.out_valid), 0);
        check("rst_out_char",     int'(bus.out_char), 0);
        check("rst_frame_error",  int'(bus.frame_error), 0);
        check("rst_parity_error", int'(bus.parity_error), 0);
        check("rst_busy",         int'(bus.busy), 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table vectors
        foreach (vecs[i]) begin
            pb = vecs[i].par_ok ? ^vecs[i].data : ~^vecs[i].data;
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop, pb, vecs[i].exp);
        end

        // Busy rises two cycles after rx falls
        begin
            int start, rise;
            start = cycle + 1;
            rx = 1'b0;
            rise = -1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (rise < 0 && bus.busy === 1'b1) rise = cycle;
            end
            $display("busy_rise start=%0d rise=%0d", start, rise);
            check("busy_rise_delay", rise - start, 2);
            rx = 1'b1;
            repeat (3 * D) @(negedge clk);
        end

        // 3-cycle glitch on idle line
        v0 = valid_cnt; b0 = busy_cycles;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * D) @(negedge clk);
        $display("glitch busy_cycles=%0d valid=+%0d", busy_cycles - b0, valid_cnt - v0);
        check("glitch_valid", valid_cnt - v0, 0);
        check_range("glitch_busy_cycles", busy_cycles - b0, 7, 9);
        check("glitch_idle", int'(bus.busy), 0);

        // Back-to-back "1F\r\n"
        msg[0] = 8'h31; msg[1] = 8'h46; msg[2] = 8'h0D; msg[3] = 8'h0A;
        got_q.delete();
        v0 = valid_cnt;
        for (int i = 0; i < 4; i++) send_frame(msg[i], 1'b1, ^msg[i]);
        rx = 1'b1;
        repeat (2 * D) @(negedge clk);
        $display("b2b received %0d characters", got_q.size());
        check("b2b_count", valid_cnt - v0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_char%0d", i), (i < got_q.size()) ? int'(got_q[i]) : -1, int'(msg[i]));
        end
        exp_last_char = msg[3];

        // Break: 0x55 with low stop bit, line held low
        v0 = valid_cnt; f0 = frame_cnt;
        send_frame(8'h55, 1'b0, ^8'h55);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        $display("break frame=+%0d valid=+%0d busy=%0b", frame_cnt - f0, valid_cnt - v0, bus.busy);
        check("break_frame_once", frame_cnt - f0, 1);
        check("break_no_valid",   valid_cnt - v0, 0);
        check("break_busy_held",  int'(bus.busy), 1);
        rx = 1'b1;
        repeat (2 * D) @(negedge clk);
        check("break_exit_idle",  int'(bus.busy), 0);
        check("break_frame_total", frame_cnt - f0, 1);
        check("break_char_held",  int'(bus.out_char), int'(exp_last_char));

        // Reset in the middle of 0xA5
        v0 = valid_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d_a5(i));
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        $display("mid-char reset busy=%0b out_char=0x%02h", bus.busy, bus.out_char);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_char",  int'(bus.out_char), 0);
        check("midrst_frame",     int'(bus.frame_error), 0);
        check("midrst_busy",      int'(bus.busy), 0);
        reset_n = 1'b1;
        exp_last_char = 8'h00;
        repeat (2 * D) @(negedge clk);
        check("midrst_no_valid", valid_cnt - v0, 0);
        run_frame("after_rst", 8'h3C, 1'b1, ^8'h3C, 3'b100);

        // Random characters against the model
        for (int i = 0; i < 20; i++) begin
            d    = 8'($urandom_range(0, 255));
            s    = ($urandom_range(0, 5) != 0);
            pbad = ($urandom_range(0, 3) == 0);
            pb   = (^d) ^ pbad;
            run_frame($sformatf("rnd%0d", i), d, s, pb, model_outcome(d, s, pb));
        end

        check("exclusive_pulses", excl_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic d_a5(input int i);
        logic [7:0] v;
        v = 8'hA5;
        return v[i];
    endfunction

endmodule
